// File: rtl/uart_tx_engine_if.sv
// Word handshake between the UART write-FIFO pop logic (master) and the tx engine (slave).
// tx_busy is the only backpressure: the master must not pop while it is high.
interface uart_tx_engine_if;
   logic        tx_ena;
   logic [31:0] tx_data;
   logic        tx_busy;

   modport master (output tx_ena, output tx_data, input tx_busy);
   modport slave  (input tx_ena, input tx_data, output tx_busy);
endinterface

// File: rtl/uart_tx_engine.sv
// 8N1 serialiser for one 32-bit word per handshake, LSB byte first, optional NUL-byte suppression.
// Accepts on tx_ena && !tx_busy; busy for BYTES + 10*CLKS_PER_BIT*(bytes sent) cycles; tx/tx_busy registered.
module uart_tx_engine #(
   parameter int CLKS_PER_BIT = 434,
   parameter int BYTES        = 4,
   parameter int NUL_SKIP     = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   uart_tx_engine_if.slave        fifo,
   output logic                   tx
);

   localparam int                 CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0]   BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [1:0]         SLOT_LAST = 2'(BYTES - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   logic [2:0]       state;
   logic [1:0]       slot;
   logic [CNT_W-1:0] baud;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic [31:0]      word;
   logic             busy;

   logic [7:0]       slot_byte;
   logic             baud_end;
   logic             skip_slot;

   assign slot_byte    = word[{slot, 3'b000} +: 8];
   assign baud_end     = (baud == BAUD_LAST);
   assign skip_slot    = (NUL_SKIP != 0) && (slot_byte == 8'h00);
   assign fifo.tx_busy = busy;

   // tx is updated on the same edge as the state change so the line never lags the FSM
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         slot    <= 2'd0;
         baud    <= '0;
         bit_idx <= 3'd0;
         shift   <= 8'h00;
         word    <= 32'h0;
         busy    <= 1'b0;
         tx      <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               tx <= 1'b1;
               if (fifo.tx_ena) begin
                  word  <= fifo.tx_data;
                  slot  <= 2'd0;
                  busy  <= 1'b1;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (skip_slot) begin
                  if (slot == SLOT_LAST) begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     slot <= slot + 2'd1;
                  end
               end else begin
                  shift <= slot_byte;
                  baud  <= '0;
                  tx    <= 1'b0;
                  state <= S_START;
               end
            end
            S_START: begin
               if (baud_end) begin
                  baud    <= '0;
                  bit_idx <= 3'd0;
                  tx      <= shift[0];
                  state   <= S_DATA;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_end) begin
                  baud <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= {1'b0, shift[7:1]};
                     tx      <= shift[1];
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_end) begin
                  baud <= '0;
                  if (slot == SLOT_LAST) begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     slot  <= slot + 2'd1;
                     state <= S_LOAD;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               tx    <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
